// File: rtl/ber_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ber_test_sequencer
// Description : Runs one BER measurement on the PRBS receiver. It seeds the
//               receiver, checks pattern lock over a short window, then counts
//               bits and errors and publishes the latched results.
// Revision    : 1.0 - initial release
// ============================================================================
module ber_test_sequencer #(
    parameter int SEED_BITS    = 7,
    parameter int LOCK_WINDOW  = 1024,
    parameter int LOCK_MAX_ERR = 4,
    parameter int MEAS_BITS    = 10_000_000,
    parameter int MAX_RETRY    = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_err,
    output logic             get_word,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             fail,
    output logic [2:0]       retry_count,
    output logic [CNT_W-1:0] error_bits_out,
    output logic [CNT_W-1:0] total_bits_out
);

    // One bit counter is shared by all phases; size it for the longest phase.
    localparam int SEED_CW = $clog2(SEED_BITS + 1) + 1;
    localparam int LOCK_CW = $clog2(LOCK_WINDOW) + 1;
    localparam int MEAS_CW = $clog2(MEAS_BITS) + 1;
    localparam int BW_SL   = (SEED_CW > LOCK_CW) ? SEED_CW : LOCK_CW;
    localparam int BW      = (BW_SL > MEAS_CW) ? BW_SL : MEAS_CW;
    // Lock error counter only needs to reach LOCK_MAX_ERR+1 (early exit).
    localparam int LEW     = $clog2(LOCK_MAX_ERR + 2) + 1;
    localparam logic [CNT_W-1:0] TOTAL_OUT = CNT_W'(MEAS_BITS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEED = 3'd1,
        S_LOCK = 3'd2,
        S_MEAS = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state, state_next;
    logic             seed_first, seed_first_next;
    logic [BW-1:0]    bit_cnt, bit_cnt_next;
    logic [LEW-1:0]   lock_err, lock_err_next, lock_err_inc;
    logic [CNT_W-1:0] meas_err, meas_err_next, meas_err_inc;
    logic [2:0]       retry, retry_next, retry_inc;
    logic             fail_q, fail_next;
    logic [CNT_W-1:0] err_res, err_res_next;
    logic [CNT_W-1:0] tot_res, tot_res_next;

    // State and counter registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            seed_first <= 1'b0;
            bit_cnt    <= '0;
            lock_err   <= '0;
            meas_err   <= '0;
            retry      <= '0;
            fail_q     <= 1'b0;
            err_res    <= '0;
            tot_res    <= '0;
        end else begin
            state      <= state_next;
            seed_first <= seed_first_next;
            bit_cnt    <= bit_cnt_next;
            lock_err   <= lock_err_next;
            meas_err   <= meas_err_next;
            retry      <= retry_next;
            fail_q     <= fail_next;
            err_res    <= err_res_next;
            tot_res    <= tot_res_next;
        end
    end

    // Next-state and counter update logic; abort outranks normal flow.
    always_comb begin
        state_next      = state;
        seed_first_next = seed_first;
        bit_cnt_next    = bit_cnt;
        lock_err_next   = lock_err;
        meas_err_next   = meas_err;
        retry_next      = retry;
        fail_next       = fail_q;
        err_res_next    = err_res;
        tot_res_next    = tot_res;
        lock_err_inc    = lock_err + LEW'(bit_err);
        meas_err_inc    = (bit_err && (meas_err != '1)) ? meas_err + 1'b1 : meas_err;
        retry_inc       = retry + 3'd1;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next      = S_SEED;
                    seed_first_next = 1'b1;
                    bit_cnt_next    = '0;
                    retry_next      = '0;
                    fail_next       = 1'b0;
                end
            end
            S_SEED: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (seed_first) begin
                    // get_word cycle: the receiver is capturing, no bit counted
                    seed_first_next = 1'b0;
                end else if (bit_valid) begin
                    if (bit_cnt == BW'(SEED_BITS)) begin
                        state_next    = S_LOCK;
                        bit_cnt_next  = '0;
                        lock_err_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            S_LOCK: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (bit_valid) begin
                    if (lock_err_inc > LEW'(LOCK_MAX_ERR)) begin
                        // Lock lost: give up early instead of finishing the window
                        retry_next = retry_inc;
                        if (retry_inc == 3'(MAX_RETRY)) begin
                            fail_next  = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            state_next      = S_SEED;
                            seed_first_next = 1'b1;
                            bit_cnt_next    = '0;
                        end
                    end else if (bit_cnt == BW'(LOCK_WINDOW - 1)) begin
                        state_next    = S_MEAS;
                        bit_cnt_next  = '0;
                        meas_err_next = '0;
                    end else begin
                        bit_cnt_next  = bit_cnt + 1'b1;
                        lock_err_next = lock_err_inc;
                    end
                end
            end
            S_MEAS: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (bit_valid) begin
                    if (bit_cnt == BW'(MEAS_BITS - 1)) begin
                        // Final bit is included; results become visible with done
                        state_next   = S_DONE;
                        err_res_next = meas_err_inc;
                        tot_res_next = TOTAL_OUT;
                    end else begin
                        bit_cnt_next  = bit_cnt + 1'b1;
                        meas_err_next = meas_err_inc;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign get_word       = (state == S_SEED) && seed_first;
    assign busy           = (state == S_SEED) || (state == S_LOCK) || (state == S_MEAS);
    assign locked         = (state == S_MEAS);
    assign done           = (state == S_DONE);
    assign fail           = fail_q;
    assign retry_count    = retry;
    assign error_bits_out = err_res;
    assign total_bits_out = tot_res;

endmodule
`default_nettype wire

// File: tb/tb_ber_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ber_test_sequencer
// Description : Scoreboard bench for ber_test_sequencer. A phase-level model
//               plans each run's stimulus and predicts its outcome; a monitor
//               compares every run end against the queued prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ber_test_sequencer;

    localparam int SB   = 7;
    localparam int LW   = 16;
    localparam int LME  = 1;
    localparam int MB   = 100;
    localparam int MR   = 2;
    localparam int NMAX = 1024;

    localparam int K_DONE = 0, K_FAIL = 1, K_ABORT = 2;
    localparam int P_CLEAN = 0, P_MEAS5 = 1, P_LOCK1 = 2, P_ALLERR = 3,
                   P_ABORT = 4, P_SATUR = 5, P_RAND = 6;

    logic clk = 1'b0;
    logic rst, start, abort, bit_valid, bit_err;
    logic       get_word_a, busy_a, locked_a, done_a, fail_a;
    logic [2:0] retry_a;
    logic [7:0] err_a, tot_a;
    logic       get_word_b, busy_b, locked_b, done_b, fail_b;
    logic [2:0] retry_b;
    logic [3:0] err_b, tot_b;

    ber_test_sequencer #(.SEED_BITS(SB), .LOCK_WINDOW(LW), .LOCK_MAX_ERR(LME),
                         .MEAS_BITS(MB), .MAX_RETRY(MR), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_err(bit_err),
        .get_word(get_word_a), .busy(busy_a), .locked(locked_a), .done(done_a),
        .fail(fail_a), .retry_count(retry_a),
        .error_bits_out(err_a), .total_bits_out(tot_a));

    ber_test_sequencer #(.SEED_BITS(SB), .LOCK_WINDOW(LW), .LOCK_MAX_ERR(LME),
                         .MEAS_BITS(MB), .MAX_RETRY(MR), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_err(bit_err),
        .get_word(get_word_b), .busy(busy_b), .locked(locked_b), .done(done_b),
        .fail(fail_b), .retry_count(retry_b),
        .error_bits_out(err_b), .total_bits_out(tot_b));

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     kind;
        longint end_c;
        longint gw_c;
        int     ea, eb, ta, tb, retry, gw, lk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // planned per-cycle stimulus for one run (index 0 = start cycle)
    bit pv[NMAX], pe[NMAX], pa[NMAX], ps[NMAX];
    int e_kind, e_end, e_gw, e_lk, e_retry;
    int last_ea = 0, last_eb = 0, last_ta = 0, last_tb = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit vbit(input int m, input int k);
        if (m == 0) return 1'b1;
        if (m == 1) return 1'((k % 2) == 1);
        return 1'($urandom_range(0, 2) != 0);
    endfunction

    function automatic bit lock_err_of(input int prof, input int att);
        if (prof == P_LOCK1)  return 1'(att == 0);
        if (prof == P_ALLERR) return 1'b1;
        if (prof == P_RAND)   return 1'($urandom_range(0, 11) == 0);
        return 1'b0;
    endfunction

    function automatic bit meas_err_of(input int prof, input int tot, input int off);
        if (prof == P_MEAS5) return 1'((tot % 20) == off);
        if (prof == P_SATUR || prof == P_ALLERR) return 1'b1;
        if (prof == P_RAND)  return 1'($urandom_range(0, 3) == 0);
        return 1'b0;
    endfunction

    // Walk the run phase by phase: seed capture, lock window, measurement.
    task automatic plan(input int prof, input int vmode, input int ab_in);
        int k, need, cnt, le, tot, me, att, ab, off;
        ab  = ab_in;
        off = $urandom_range(0, 19);
        for (int i = 0; i < NMAX; i++) begin
            pv[i] = 1'($urandom_range(0, 1));
            pe[i] = 1'($urandom_range(0, 1));
            pa[i] = 1'b0;
            ps[i] = 1'b0;
        end
        ps[0] = 1'b1;
        k = 1; att = 0; me = 0; e_gw = 0; e_lk = 0; e_kind = K_ABORT;
        while (1) begin
            e_gw++;                       // get_word cycle, bit ignored
            if (k == ab) break;
            k++;
            need = SB + 1;
            while (need > 0 && k != ab) begin
                pv[k] = vbit(vmode, k);
                if (pv[k]) need--;
                k++;
            end
            if (need > 0) break;
            cnt = 0; le = 0;
            while (cnt < LW && le <= LME && k != ab) begin
                pv[k] = vbit(vmode, k);
                if (pv[k]) begin
                    pe[k] = lock_err_of(prof, att);
                    cnt++;
                    le += int'(pe[k]);
                end
                k++;
            end
            if (le > LME) begin
                att++;
                if (att == MR) begin
                    e_kind = K_FAIL;
                    break;
                end
                continue;
            end
            if (cnt < LW) break;          // aborted inside the lock window
            tot = 0;
            while (tot < MB) begin
                if (prof == P_ABORT && tot == 50 && ab == 0) ab = k;
                e_lk++;
                if (k == ab) break;
                pv[k] = vbit(vmode, k);
                if (pv[k]) begin
                    pe[k] = meas_err_of(prof, tot, off);
                    tot++;
                    me += int'(pe[k]);
                end
                k++;
            end
            if (tot == MB) e_kind = K_DONE;
            break;
        end
        e_retry = att;
        if (e_kind == K_ABORT) begin
            pa[k] = 1'b1;
            e_end = k + 1;
        end else begin
            e_end = k;
        end
        for (int i = 1; i < e_end; i++) ps[i] = 1'($urandom_range(0, 7) == 0);
        if (e_kind == K_DONE) begin
            pa[e_end] = 1'($urandom_range(0, 1));
            last_ea = me;
            last_eb = (me > 15) ? 15 : me;
            last_ta = MB % 256;
            last_tb = MB % 16;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_ea = 0; last_eb = 0; last_ta = 0; last_tb = 0;
    endtask

    task automatic run(input int prof, input int vmode, input int ab);
        exp_t e;
        int   w;
        plan(prof, vmode, ab);
        @(negedge clk);
        e.kind = e_kind;     e.end_c = cyc + e_end; e.gw_c = cyc + 1;
        e.ea = last_ea;      e.eb = last_eb;  e.ta = last_ta; e.tb = last_tb;
        e.retry = e_retry;   e.gw = e_gw;     e.lk = e_lk;
        sb.push_back(e);
        for (int k = 0; k <= e_end; k++) begin
            if (k > 0) @(negedge clk);
            start = ps[k]; abort = pa[k]; bit_valid = pv[k]; bit_err = pe[k];
        end
        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            w++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL run_timeout actual=still_busy expected=end_by_cycle_%0d", e.end_c);
            sb.delete();
            do_reset();
        end
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'($urandom_range(0, 1));
            bit_valid = 1'($urandom_range(0, 1));
            bit_err = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: a run ends when busy drops; compare against the queued prediction.
    initial begin
        bit     busy_prev;
        int     gw_n, lk_n;
        longint first_gw;
        exp_t   e;
        busy_prev = 1'b0; gw_n = 0; lk_n = 0; first_gw = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0; gw_n = 0; lk_n = 0; first_gw = -1;
            end else begin
                if (get_word_a) begin
                    gw_n++;
                    if (first_gw < 0) first_gw = cyc;
                end
                if (locked_a) lk_n++;
                if (busy_prev && !busy_a) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_end actual=end_at_%0d expected=no_run", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("end_cycle",   cyc,        e.end_c);
                        chk("getword_cyc", first_gw,   e.gw_c);
                        chk("getword_cnt", gw_n,       e.gw);
                        chk("locked_cnt",  lk_n,       e.lk);
                        chk("done_a",      done_a,     e.kind == K_DONE);
                        chk("fail_a",      fail_a,     e.kind == K_FAIL);
                        chk("retry_a",     retry_a,    e.retry);
                        chk("errors_a",    err_a,      e.ea);
                        chk("total_a",     tot_a,      e.ta);
                        chk("busy_b",      busy_b,     0);
                        chk("done_b",      done_b,     e.kind == K_DONE);
                        chk("fail_b",      fail_b,     e.kind == K_FAIL);
                        chk("retry_b",     retry_b,    e.retry);
                        chk("errors_b",    err_b,      e.eb);
                        chk("total_b",     tot_b,      e.tb);
                    end
                    gw_n = 0; lk_n = 0; first_gw = -1;
                end else if (done_a || done_b) begin
                    checks++; errors++;
                    $display("FAIL stray_done actual=1 expected=0 (cycle %0d)", cyc);
                end
                busy_prev = busy_a;
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog actual=not_finished expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy",     busy_a,     0);
        chk("rst_getword",  get_word_a, 0);
        chk("rst_locked",   locked_a,   0);
        chk("rst_done",     done_a,     0);
        chk("rst_fail",     fail_a,     0);
        chk("rst_retry",    retry_a,    0);
        chk("rst_errors",   err_a,      0);
        chk("rst_total",    tot_a,      0);
        chk("rst_errors_b", err_b,      0);
        rst = 1'b0;
        @(negedge clk);

        run(P_CLEAN,  0, 0);   // clean run, reference latency
        run(P_MEAS5,  0, 0);   // five measurement errors
        run(P_LOCK1,  0, 0);   // one reseed, then lock
        run(P_ALLERR, 0, 0);   // retries exhausted, results held
        run(P_ABORT,  0, 0);   // abort mid-measurement
        run(P_CLEAN,  0, 0);   // clean again after abort
        run(P_SATUR,  0, 0);   // 4-bit error counter saturates
        run(P_SATUR,  1, 0);   // same with bit_valid toggling
        for (int i = 0; i < 30; i++) begin
            run($urandom_range(0, 6), $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 250) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
